// File: rtl/awgn_stats_mon.sv
`timescale 1ns/1ps
// awgn_stats_mon
// Block statistics monitor for the two AWGN generator output channels.
// A run is requested with a single-cycle start. The block then accumulates
// 2^LOG2N accepted sample pairs and reports, per channel:
// - the window mean (signed Q5.11)
// - the mean power, or mean of squares (unsigned Q10.22)
// - the number of samples whose magnitude reaches THRESH
// A one-cycle done pulse accompanies each result update.
//
// Parameters
//   LOG2N   log2 of the window length N (1..16)
//   THRESH  outlier magnitude threshold, unsigned Q5.11
//
// Ports
//   clk                   single rising-edge clock
//   reset                 synchronous active-high reset
//   start                 run request, only honoured while idle
//   in_valid              awgn_in_0/1 carry a sample pair this cycle
//   awgn_in_0, awgn_in_1  signed Q5.11 samples
//   busy                  high while accumulating
//   done                  one-cycle pulse when the result registers update
//   mean_0, mean_1        signed Q5.11 window means
//   pow_0, pow_1          unsigned Q10.22 window mean of squares
//   outl_0, outl_1        outlier counts (LOG2N+1 bits, so N itself fits)

module awgn_stats_mon #(
  parameter int          LOG2N  = 10,
  parameter logic [15:0] THRESH = 16'd6144
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [15:0]      awgn_in_0,
  input  logic [15:0]      awgn_in_1,
  output logic             busy,
  output logic             done,
  output logic [15:0]      mean_0,
  output logic [15:0]      mean_1,
  output logic [31:0]      pow_0,
  output logic [31:0]      pow_1,
  output logic [LOG2N:0]   outl_0,
  output logic [LOG2N:0]   outl_1
);

  // The sum needs LOG2N guard bits above the 16-bit sample. The square sum
  // needs LOG2N bits above the 31-bit worst-case square (2^30 at -32768).
  localparam int SUM_W = 16 + LOG2N;
  localparam int SQ_W  = 31 + LOG2N;
  localparam int CNT_W = LOG2N + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2N) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0]       x      [2];
  logic [16:0]       mag    [2];
  logic [30:0]       sqr    [2];
  logic              hit    [2];
  logic [SUM_W-1:0]  x_ext  [2];

  logic [SUM_W-1:0]  sum      [2];
  logic [SQ_W-1:0]   sq       [2];
  logic [CNT_W-1:0]  outl_cnt [2];
  logic [CNT_W-1:0]  cnt;

  logic [15:0]       mean_r [2];
  logic [31:0]       pow_r  [2];
  logic [CNT_W-1:0]  outl_r [2];

  assign x[0] = awgn_in_0;
  assign x[1] = awgn_in_1;

  // Per-channel sample preprocessing, shared by both accumulator lanes.
  // The magnitude is formed at 17 bits so that -32768 maps to +32768
  // rather than wrapping. Squaring the magnitude gives the same result as
  // squaring the signed sample, and it keeps the multiplier unsigned and
  // exactly 31 bits wide.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mag[k]   = x[k][15] ? (17'd0 - {1'b1, x[k]}) : {1'b0, x[k]};
      sqr[k]   = 31'(mag[k]) * 31'(mag[k]);
      hit[k]   = (mag[k] >= {1'b0, THRESH});
      x_ext[k] = {{LOG2N{x[k][15]}}, x[k]};
    end
  end

  // State register. The run is abandoned outright on reset, whatever
  // phase it was in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and busy decode. A start seen outside IDLE is dropped
  // rather than remembered. The exit from ACCUM is taken on the very cycle
  // that accepts the last sample, so FIN always sees complete accumulators.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        busy = 1'b1;
        if (in_valid && (cnt == CNT_LAST)) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Accumulators, window counter and result registers.
  // IDLE continuously clears the accumulators, so a new run always starts
  // from zero, including a back-to-back run that passes through IDLE for
  // only one cycle. FIN captures the results from the final accumulator
  // values and raises done in the same edge, so done and the new results
  // appear together.
  // The mean is the arithmetic shift of the sum by LOG2N truncated to
  // 16 bits, which is exactly the 16-bit slice above the fraction bits.
  // The power slice is 31 bits wide, so bit 31 of pow is always zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        sum[k]      <= '0;
        sq[k]       <= '0;
        outl_cnt[k] <= '0;
        mean_r[k]   <= '0;
        pow_r[k]    <= '0;
        outl_r[k]   <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          for (int k = 0; k < 2; k++) begin
            sum[k]      <= '0;
            sq[k]       <= '0;
            outl_cnt[k] <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            cnt <= cnt + CNT_W'(1);
            for (int k = 0; k < 2; k++) begin
              sum[k]      <= sum[k] + x_ext[k];
              sq[k]       <= sq[k] + SQ_W'(sqr[k]);
              outl_cnt[k] <= outl_cnt[k] + CNT_W'(hit[k]);
            end
          end
        end
        FIN: begin
          done <= 1'b1;
          for (int k = 0; k < 2; k++) begin
            mean_r[k] <= sum[k][LOG2N +: 16];
            pow_r[k]  <= {1'b0, sq[k][LOG2N +: 31]};
            outl_r[k] <= outl_cnt[k];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mean_0 = mean_r[0];
  assign mean_1 = mean_r[1];
  assign pow_0  = pow_r[0];
  assign pow_1  = pow_r[1];
  assign outl_0 = outl_r[0];
  assign outl_1 = outl_r[1];

endmodule

// File: tb/tb_awgn_stats_mon.sv
`timescale 1ns/1ps
// tb_awgn_stats_mon
// Testbench for awgn_stats_mon.
// It drives a small-window instance (LOG2N=2) with directed and random
// sample windows, and a full-size instance (LOG2N=16) with a saturating
// window of -32768 samples.
// Expected results come from a plain-arithmetic reference model:
// - floor of the mean
// - integer mean of the squares
// - a magnitude count against the threshold

module tb_awgn_stats_mon;

  localparam int LOG2N  = 2;
  localparam int N      = 1 << LOG2N;
  localparam int THRESH = 6144;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic [15:0]  awgn_in_0;
  logic [15:0]  awgn_in_1;
  logic         busy;
  logic         done;
  logic [15:0]  mean_0;
  logic [15:0]  mean_1;
  logic [31:0]  pow_0;
  logic [31:0]  pow_1;
  logic [LOG2N:0] outl_0;
  logic [LOG2N:0] outl_1;

  logic         start_b;
  logic         valid_b;
  logic         busy_b;
  logic         done_b;
  logic [15:0]  mean_0_b;
  logic [15:0]  mean_1_b;
  logic [31:0]  pow_0_b;
  logic [31:0]  pow_1_b;
  logic [16:0]  outl_0_b;
  logic [16:0]  outl_1_b;

  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;

  awgn_stats_mon #(.LOG2N(LOG2N), .THRESH(16'd6144)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .awgn_in_0 (awgn_in_0),
    .awgn_in_1 (awgn_in_1),
    .busy      (busy),
    .done      (done),
    .mean_0    (mean_0),
    .mean_1    (mean_1),
    .pow_0     (pow_0),
    .pow_1     (pow_1),
    .outl_0    (outl_0),
    .outl_1    (outl_1)
  );

  awgn_stats_mon #(.LOG2N(16), .THRESH(16'd6144)) dut_big (
    .clk       (clk),
    .reset     (reset),
    .start     (start_b),
    .in_valid  (valid_b),
    .awgn_in_0 (16'h8000),
    .awgn_in_1 (16'h8000),
    .busy      (busy_b),
    .done      (done_b),
    .mean_0    (mean_0_b),
    .mean_1    (mean_1_b),
    .pow_0     (pow_0_b),
    .pow_1     (pow_1_b),
    .outl_0    (outl_0_b),
    .outl_1    (outl_1_b)
  );

  always #5 clk = ~clk;

  // Count done pulses of the small instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  // Reference model: floor(sum / N), computed on plain integers.
  function automatic logic [15:0] expMean(input int q[$]);
    longint s;
    longint f;
    s = 0;
    foreach (q[i]) s += longint'(q[i]);
    f = s / N;
    if (s < 0 && (s % N) != 0) f = f - 1;
    return 16'(f);
  endfunction

  // Reference model: integer mean of the squares.
  function automatic logic [31:0] expPow(input int q[$]);
    longint s;
    s = 0;
    foreach (q[i]) s += longint'(q[i]) * longint'(q[i]);
    return 32'(s / N);
  endfunction

  // Reference model: number of samples with |x| >= THRESH.
  function automatic int expOutl(input int q[$]);
    int c;
    c = 0;
    foreach (q[i]) if (((q[i] < 0) ? -q[i] : q[i]) >= THRESH) c++;
    return c;
  endfunction

  // Random sample, biased toward the extremes and the threshold edges.
  function automatic int randSample();
    logic [15:0] r;
    int pick;
    r = 16'($urandom);
    pick = int'($urandom_range(0, 5));
    case (pick)
      0:       return -32768;
      1:       return 32767;
      2:       return ($urandom_range(0, 1) == 1) ? 6144 : -6144;
      3:       return ($urandom_range(0, 1) == 1) ? 6143 : -6143;
      default: return int'($signed(r));
    endcase
  endfunction

  task automatic applyStimulus(input logic st, input logic v, input logic [15:0] a0,
                               input logic [15:0] a1);
    start     = st;
    in_valid  = v;
    awgn_in_0 = a0;
    awgn_in_1 = a1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full window on the small instance. The task:
  // - raises start
  // - feeds the four sample pairs with optional idle gaps, during which
  //   stray start pulses are sent and must be ignored
  // - checks the FIN, done and hold behaviour around the result update
  task automatic runWindow(input string tag, input int q0[$], input int q1[$],
                           input int maxGap, input bit holdStart);
    logic [15:0] em0, em1;
    logic [31:0] ep0, ep1;
    int eo0, eo1, base, gap;
    em0 = expMean(q0);
    em1 = expMean(q1);
    ep0 = expPow(q0);
    ep1 = expPow(q1);
    eo0 = expOutl(q0);
    eo1 = expOutl(q1);
    applyStimulus(1'b1, 1'b0, 16'($urandom), 16'($urandom));
    checkOutput({tag, " busy after start"}, 64'(busy), 64'd1);
    for (int i = 0; i < N; i++) begin
      gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      repeat (gap) applyStimulus(holdStart | ($urandom_range(0, 3) == 0), 1'b0,
                                 16'($urandom), 16'($urandom));
      applyStimulus(holdStart, 1'b1, 16'(q0[i]), 16'(q1[i]));
    end
    checkOutput({tag, " busy in FIN"}, 64'(busy), 64'd0);
    checkOutput({tag, " done early"}, 64'(done), 64'd0);
    base = done_seen;
    applyStimulus(holdStart, 1'b0, 16'($urandom), 16'($urandom));
    checkOutput({tag, " done"}, 64'(done), 64'd1);
    checkOutput({tag, " mean_0"}, 64'(mean_0), 64'(em0));
    checkOutput({tag, " mean_1"}, 64'(mean_1), 64'(em1));
    checkOutput({tag, " pow_0"}, 64'(pow_0), 64'(ep0));
    checkOutput({tag, " pow_1"}, 64'(pow_1), 64'(ep1));
    checkOutput({tag, " outl_0"}, 64'(outl_0), 64'(eo0));
    checkOutput({tag, " outl_1"}, 64'(outl_1), 64'(eo1));
    if (holdStart) begin
      applyStimulus(1'b1, 1'b0, 16'($urandom), 16'($urandom));
      checkOutput({tag, " restart busy"}, 64'(busy), 64'd1);
      checkOutput({tag, " restart done"}, 64'(done), 64'd0);
    end else begin
      applyStimulus(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      checkOutput({tag, " done cleared"}, 64'(done), 64'd0);
      checkOutput({tag, " idle busy"}, 64'(busy), 64'd0);
      checkOutput({tag, " mean_0 held"}, 64'(mean_0), 64'(em0));
    end
    checkOutput({tag, " done pulses"}, 64'(done_seen - base), 64'd1);
  endtask

  initial begin
    int q0[$];
    int q1[$];
    int pat[7];
    int j;
    int base;

    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    awgn_in_0 = '0;
    awgn_in_1 = '0;
    start_b   = 1'b0;
    valid_b   = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset values");
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset mean_0", 64'(mean_0), 64'd0);
    checkOutput("reset mean_1", 64'(mean_1), 64'd0);
    checkOutput("reset pow_0", 64'(pow_0), 64'd0);
    checkOutput("reset pow_1", 64'(pow_1), 64'd0);
    checkOutput("reset outl_0", 64'(outl_0), 64'd0);
    checkOutput("reset outl_1", 64'(outl_1), 64'd0);
    checkOutput("reset busy_b", 64'(busy_b), 64'd0);
    checkOutput("reset done_b", 64'(done_b), 64'd0);
    reset = 1'b0;

    // Valid samples while idle must not start or disturb anything.
    applyStimulus(1'b0, 1'b1, 16'h7fff, 16'h8000);
    applyStimulus(1'b0, 1'b1, 16'h1234, 16'h4321);
    checkOutput("idle valid busy", 64'(busy), 64'd0);
    checkOutput("idle valid done", 64'(done), 64'd0);

    $display("[TB] constant window");
    q0 = '{2048, 2048, 2048, 2048};
    runWindow("t1", q0, q0, 0, 1'b0);
    checkOutput("t1 mean const", 64'(mean_0), 64'h0800);
    checkOutput("t1 pow const", 64'(pow_1), 64'h0040_0000);

    $display("[TB] threshold and truncation window");
    q0 = '{6144, -6144, 6144, -6144};
    q1 = '{1, 0, 0, 0};
    runWindow("t2", q0, q1, 0, 1'b0);
    checkOutput("t2 pow_0 const", 64'(pow_0), 64'h0240_0000);
    checkOutput("t2 outl_0 const", 64'(outl_0), 64'd4);
    checkOutput("t2 pow_1 const", 64'(pow_1), 64'd0);

    $display("[TB] negative extremes window");
    q0 = '{-1, 0, 0, 0};
    q1 = '{-32768, -32768, -32768, -32768};
    runWindow("t3", q0, q1, 0, 1'b0);
    checkOutput("t3 mean_0 const", 64'(mean_0), 64'hffff);
    checkOutput("t3 mean_1 const", 64'(mean_1), 64'h8000);
    checkOutput("t3 pow_1 const", 64'(pow_1), 64'h4000_0000);
    checkOutput("t3 outl_1 const", 64'(outl_1), 64'd4);

    $display("[TB] stalled run with ignored start");
    q0.delete();
    q1.delete();
    for (int i = 0; i < N; i++) begin
      q0.push_back(randSample());
      q1.push_back(randSample());
    end
    pat = '{1, 0, 0, 1, 1, 0, 1};
    j = 0;
    applyStimulus(1'b1, 1'b0, 16'd0, 16'd0);
    base = done_seen;
    for (int c = 0; c < 7; c++) begin
      checkOutput($sformatf("t4 busy cycle %0d", c), 64'(busy), 64'd1);
      if (pat[c] == 1) begin
        applyStimulus(1'b0, 1'b1, 16'(q0[j]), 16'(q1[j]));
        j++;
      end else begin
        applyStimulus(c == 2, 1'b0, 16'($urandom), 16'($urandom));
      end
    end
    checkOutput("t4 busy in FIN", 64'(busy), 64'd0);
    checkOutput("t4 done early", 64'(done), 64'd0);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0);
    checkOutput("t4 done", 64'(done), 64'd1);
    checkOutput("t4 mean_0", 64'(mean_0), 64'(expMean(q0)));
    checkOutput("t4 mean_1", 64'(mean_1), 64'(expMean(q1)));
    checkOutput("t4 pow_0", 64'(pow_0), 64'(expPow(q0)));
    checkOutput("t4 outl_1", 64'(outl_1), 64'(expOutl(q1)));
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0);
    checkOutput("t4 single done", 64'(done_seen - base), 64'd1);
    checkOutput("t4 start not queued", 64'(busy), 64'd0);

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 1'b0, 16'd0, 16'd0);
    applyStimulus(1'b0, 1'b1, 16'h0400, 16'h0400);
    applyStimulus(1'b0, 1'b1, 16'h0400, 16'h0400);
    base = done_seen;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0400, 16'h0400);
    reset = 1'b0;
    checkOutput("t5 busy after reset", 64'(busy), 64'd0);
    checkOutput("t5 done after reset", 64'(done), 64'd0);
    checkOutput("t5 mean_0 cleared", 64'(mean_0), 64'd0);
    checkOutput("t5 mean_1 cleared", 64'(mean_1), 64'd0);
    checkOutput("t5 pow_0 cleared", 64'(pow_0), 64'd0);
    checkOutput("t5 pow_1 cleared", 64'(pow_1), 64'd0);
    checkOutput("t5 outl_0 cleared", 64'(outl_0), 64'd0);
    checkOutput("t5 outl_1 cleared", 64'(outl_1), 64'd0);
    checkOutput("t5 no done", 64'(done_seen - base), 64'd0);
    q0 = '{1024, 1024, 1024, 1024};
    runWindow("t5 rerun", q0, q0, 0, 1'b0);
    checkOutput("t5 mean const", 64'(mean_0), 64'h0400);
    checkOutput("t5 pow const", 64'(pow_0), 64'h0010_0000);

    $display("[TB] back-to-back runs with start held");
    for (int r = 0; r < 3; r++) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < N; i++) begin
        q0.push_back(randSample());
        q1.push_back(randSample());
      end
      runWindow($sformatf("b2b%0d", r), q0, q1, 1, r < 2);
    end

    $display("[TB] random windows");
    for (int r = 0; r < 12; r++) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < N; i++) begin
        q0.push_back(randSample());
        q1.push_back(randSample());
      end
      applyStimulus(1'b0, 1'b1, 16'($urandom), 16'($urandom));
      runWindow($sformatf("rand%0d", r), q0, q1, 3, 1'b0);
    end

    $display("[TB] full-size window of -32768");
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    valid_b = 1'b1;
    checkOutput("big busy", 64'(busy_b), 64'd1);
    repeat (65536) @(posedge clk);
    #1;
    valid_b = 1'b0;
    checkOutput("big busy in FIN", 64'(busy_b), 64'd0);
    checkOutput("big done early", 64'(done_b), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("big done", 64'(done_b), 64'd1);
    checkOutput("big mean_0", 64'(mean_0_b), 64'h8000);
    checkOutput("big mean_1", 64'(mean_1_b), 64'h8000);
    checkOutput("big pow_0", 64'(pow_0_b), 64'h4000_0000);
    checkOutput("big pow_1", 64'(pow_1_b), 64'h4000_0000);
    checkOutput("big outl_0", 64'(outl_0_b), 64'd65536);
    checkOutput("big outl_1", 64'(outl_1_b), 64'd65536);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
